// File: rtl/ro_trng.sv
// Ring-oscillator TRNG. NUM_RO NAND-gated rings are synchronised, XOR-combined,
// flushed after enable, optionally Von Neumann debiased (RO_TRNG_VN_DEBIAS_EN),
// repetition-count health tested and packed into OUT_WIDTH words (valid/ready).
module ro_trng #(
  parameter int NUM_RO    = 4,
  parameter int NUM_INV   = 3,
  parameter int OUT_WIDTH = 8,
  parameter int REP_LIMIT = 16
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic                 en,
  input  logic                 test_mode_i,
  input  logic                 test_bit_i,
  output logic [OUT_WIDTH-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 alarm_o
);

  localparam int RC_W = $clog2(REP_LIMIT + 1);
  localparam int BC_W = $clog2(OUT_WIDTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_FILL  = 2'd2;
  localparam logic [1:0] ST_ALARM = 2'd3;

  // Rings are parked in test mode so the deterministic source runs without
  // free-running oscillators alongside it.
  logic              ro_en;
  logic              stage [NUM_RO][NUM_INV];
  logic [NUM_RO-1:0] ro_out;

  assign ro_en = en & ~test_mode_i;

  for (genvar r = 0; r < NUM_RO; r++) begin : g_ro
    // NAND gate closes the ring; with ro_en low its output is pinned high.
    assign stage[r][0] = ~(ro_en & stage[r][NUM_INV-1]);
    for (genvar i = 1; i < NUM_INV; i++) begin : g_inv
      assign stage[r][i] = ~stage[r][i-1];
    end
    assign ro_out[r] = stage[r][NUM_INV-1];
  end

  logic [NUM_RO-1:0] sync1, sync2;
  logic              raw_q;
  logic              src;

  assign src = test_mode_i ? test_bit_i : ^sync2;

  // Two-flop synchroniser per oscillator, then the raw bit register.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sync1 <= '0;
      sync2 <= '0;
      raw_q <= 1'b0;
    end else begin
      sync1 <= ro_out;
      sync2 <= sync1;
      raw_q <= src;
    end
  end

  logic [1:0]           state;
  logic                 flush_cnt;
  logic [RC_W-1:0]      run_cnt;
  logic [RC_W-1:0]      run_nxt;
  logic                 last_bit;
  logic                 collect;
  logic                 trip;
  logic                 emit_vld;
  logic                 emit_bit;
  logic [OUT_WIDTH-1:0] shreg;
  logic [OUT_WIDTH-1:0] word_nxt;
  logic [BC_W-1:0]      bit_cnt;
  logic                 word_done;

  // raw_q is consumed only in FILL with en still high; the bit that trips the
  // health test is swallowed rather than emitted.
  assign collect  = (state == ST_FILL) && en;
  assign run_nxt  = ((run_cnt == '0) || (raw_q != last_bit)) ? RC_W'(1) : run_cnt + RC_W'(1);
  assign trip     = collect && (run_nxt == RC_W'(REP_LIMIT));

`ifdef RO_TRNG_VN_DEBIAS_EN
  logic pair_ph;
  logic pair_first;

  // Second bit of each pair decides: 01 -> 0, 10 -> 1, equal pairs dropped.
  assign emit_vld = collect && !trip && pair_ph && (pair_first != raw_q);
  assign emit_bit = pair_first;

  // Pair phase restarts whenever collection is interrupted.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      pair_ph    <= 1'b0;
      pair_first <= 1'b0;
    end else if (!collect) begin
      pair_ph    <= 1'b0;
    end else if (!trip) begin
      pair_ph    <= ~pair_ph;
      if (!pair_ph) pair_first <= raw_q;
    end
  end
`else
  assign emit_vld = collect && !trip;
  assign emit_bit = raw_q;
`endif

  assign word_nxt  = {shreg[OUT_WIDTH-2:0], emit_bit};
  assign word_done = emit_vld && (bit_cnt == BC_W'(OUT_WIDTH - 1));

  // Control FSM: enable edge starts a two-cycle flush; ALARM is left only by reset.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state     <= ST_IDLE;
      flush_cnt <= 1'b0;
      alarm_o   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en) begin
            state     <= ST_FLUSH;
            flush_cnt <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (!en)           state     <= ST_IDLE;
          else if (flush_cnt) state    <= ST_FILL;
          else               flush_cnt <= 1'b1;
        end
        ST_FILL: begin
          if (trip) begin
            state   <= ST_ALARM;
            alarm_o <= 1'b1;
          end else if (!en) begin
            state   <= ST_IDLE;
          end
        end
        ST_ALARM: state <= ST_ALARM;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Repetition counter over raw bits; cleared outside active collection.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      run_cnt  <= '0;
      last_bit <= 1'b0;
    end else if (collect) begin
      run_cnt  <= run_nxt;
      last_bit <= raw_q;
    end else begin
      run_cnt  <= '0;
    end
  end

  // Word assembly: first emitted bit lands in the MSB.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (!collect) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (emit_vld) begin
      shreg   <= word_nxt;
      bit_cnt <= word_done ? '0 : bit_cnt + BC_W'(1);
    end
  end

  // Output register: a completed word is dropped if the previous one is still
  // pending without ready; alarm kills valid but keeps the last word visible.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else if ((state == ST_ALARM) || trip) begin
      valid_o <= 1'b0;
    end else if (word_done && (!valid_o || ready_i)) begin
      data_o  <= word_nxt;
      valid_o <= 1'b1;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ro_trng.sv
// Directed bench for ro_trng in test mode with a word scoreboard.
// Expected words are queued before stimulus and popped when valid_o presents a new word.
module tb_ro_trng;

  logic       clk = 1'b0;
  logic       res_n;
  logic       en;
  logic       test_mode_i;
  logic       test_bit_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       alarm_o;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  ro_trng #(
    .NUM_RO   (4),
    .NUM_INV  (3),
    .OUT_WIDTH(8),
    .REP_LIMIT(16)
  ) dut (
    .clk        (clk),
    .res_n      (res_n),
    .en         (en),
    .test_mode_i(test_mode_i),
    .test_bit_i (test_bit_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .alarm_o    (alarm_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  // One clock; a word is new when valid rises or when a transfer coincided
  // with a fresh load.
  task automatic tick();
    logic v;
    logic r;
    logic [7:0] e;
    v = valid_o;
    r = ready_i;
    @(posedge clk);
    #1;
    if (valid_o && (!v || r)) begin
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_word: got %0h want no word", data_o);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("word", {24'h0, data_o}, {24'h0, e});
      end
    end
  endtask

  task automatic raw(input logic b);
    test_bit_i = b;
    tick();
  endtask

  // One emitted bit: a single raw bit, or a b/~b pair when debiasing.
  task automatic drive_bit(input logic b);
`ifdef RO_TRNG_VN_DEBIAS_EN
    raw(b);
    raw(~b);
`else
    raw(b);
`endif
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) drive_bit(w[i]);
  endtask

  // Flush bits are ones so that a missing flush would corrupt the next word.
  task automatic start();
    en = 1'b1;
    raw(1'b1);
    raw(1'b1);
  endtask

  task automatic stop();
    en = 1'b0;
    tick();
  endtask

  initial begin
    logic [23:0] ds;
    res_n       = 1'b0;
    en          = 1'b0;
    test_mode_i = 1'b1;
    test_bit_i  = 1'b0;
    ready_i     = 1'b1;
    #12;
    chk("rst_data", {24'h0, data_o}, 32'h0);
    chk("rst_valid", {31'h0, valid_o}, 32'h0);
    chk("rst_alarm", {31'h0, alarm_o}, 32'h0);
    res_n = 1'b1;

    // Basic word with single-cycle valid pulse.
    exp_q.push_back(8'hB2);
    start();
    send_word(8'hB2);
    chk("b2_not_yet", {31'h0, valid_o}, 32'h0);
    tick();
    chk("b2_valid", {31'h0, valid_o}, 32'h1);
    chk("b2_data", {24'h0, data_o}, 32'hB2);
    tick();
    chk("b2_pulse_end", {31'h0, valid_o}, 32'h0);
    stop();

    // Reset mid-word with a pending word.
    ready_i = 1'b0;
    exp_q.push_back(8'h4D);
    start();
    send_word(8'h4D);
    tick();
    chk("4d_valid", {31'h0, valid_o}, 32'h1);
    for (int i = 0; i < 5; i++) drive_bit(1'b1);
    tick();
    res_n = 1'b0;
    en    = 1'b0;
    #1;
    chk("midrst_data", {24'h0, data_o}, 32'h0);
    chk("midrst_valid", {31'h0, valid_o}, 32'h0);
    chk("midrst_alarm", {31'h0, alarm_o}, 32'h0);
    #5;
    res_n   = 1'b1;
    ready_i = 1'b1;
    exp_q.push_back(8'hB2);
    start();
    send_word(8'hB2);
    tick();
    chk("postrst_valid", {31'h0, valid_o}, 32'h1);
    chk("postrst_data", {24'h0, data_o}, 32'hB2);
    stop();

    // Backpressure: second word dropped, first held until accepted.
    ready_i = 1'b0;
    exp_q.push_back(8'hB2);
    start();
    send_word(8'hB2);
    send_word(8'h4D);
    tick();
    chk("bp_valid", {31'h0, valid_o}, 32'h1);
    chk("bp_data", {24'h0, data_o}, 32'hB2);
    stop();
    chk("bp_held_en_low", {31'h0, valid_o}, 32'h1);
    ready_i = 1'b1;
    tick();
    chk("bp_accepted", {31'h0, valid_o}, 32'h0);

    // Enable drop discards the partial word.
    exp_q.push_back(8'hB2);
    start();
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    stop();
    start();
    send_word(8'hB2);
    tick();
    chk("endrop_valid", {31'h0, valid_o}, 32'h1);
    chk("endrop_data", {24'h0, data_o}, 32'hB2);
    stop();

    // Health test: 16 identical raw bits trip the alarm on the 16th collection.
`ifndef RO_TRNG_VN_DEBIAS_EN
    exp_q.push_back(8'hFF);
`endif
    start();
    for (int i = 0; i < 16; i++) raw(1'b1);
    chk("alarm_before", {31'h0, alarm_o}, 32'h0);
    tick();
    chk("alarm_trip", {31'h0, alarm_o}, 32'h1);
    chk("alarm_valid", {31'h0, valid_o}, 32'h0);
    for (int i = 0; i < 20; i++) raw(i[0]);
    chk("alarm_no_words", {31'h0, valid_o}, 32'h0);
    stop();
    chk("alarm_sticky", {31'h0, alarm_o}, 32'h1);
    res_n = 1'b0;
    #1;
    chk("alarm_cleared", {31'h0, alarm_o}, 32'h0);
    #5;
    res_n = 1'b1;

`ifdef RO_TRNG_VN_DEBIAS_EN
    // Von Neumann pairs: 01,10,11,00,10,01,01,10,10,01,10,01 -> word 8'h66.
    ds = 24'b0110_1100_1001_0110_1001_1001;
    exp_q.push_back(8'h66);
    start();
    for (int i = 23; i >= 0; i--) raw(ds[i]);
    tick();
    chk("debias_data", {24'h0, data_o}, 32'h66);
    stop();
`else
    ds = 24'h0;
    test_bit_i = ds[0];
`endif

    chk("scoreboard_empty", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
